// File: rtl/eth_sched_pkg.sv
// Shared encodings and default timing for the UDP/ARP transmit scheduler.
// States are plain localparams so legacy code can compare against raw state codes.
package eth_sched_pkg;

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] ARP_REQ  = 3'd1;
  localparam logic [2:0] ARP_WAIT = 3'd2;
  localparam logic [2:0] LOAD     = 3'd3;
  localparam logic [2:0] SEND     = 3'd4;
  localparam logic [2:0] WAIT_END = 3'd5;
  localparam logic [2:0] GAP      = 3'd6;

  localparam logic [1:0] SRC_NONE = 2'd0;
  localparam logic [1:0] SRC_CMD  = 2'd1;
  localparam logic [1:0] SRC_AD   = 2'd2;

  localparam logic [15:0] DEF_IFG_CYCLES    = 16'd12;
  localparam logic [31:0] DEF_TX_TIMEOUT    = 32'd125000;
  localparam logic [31:0] DEF_ARP_TIMEOUT   = 32'd12500000;
  localparam logic [3:0]  DEF_ARP_RETRY     = 4'd3;
  localparam logic [3:0]  DEF_MAX_CMD_BURST = 4'd4;
  localparam logic [15:0] DEF_MAX_UDP_LEN   = 16'd1472;

  function automatic logic [15:0] clamp_len(input logic [15:0] len, input logic [15:0] max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/eth_tx_sched_if.sv
// Request/ack and MAC-control bundle between the requesters, the scheduler and mac_top.
// master = scheduler side, slave = requesters plus MAC.
interface eth_tx_sched_if;
  logic        cmd_reply_req;
  logic [15:0] cmd_send_len;
  logic        cmd_reply_ack;
  logic        ad_data_req;
  logic [15:0] ad_send_len;
  logic        ad_data_ack;
  logic        mac_not_exist;
  logic        arp_found;
  logic        mac_send_end;
  logic        arp_request_req;
  logic        udp_tx_req;
  logic [15:0] udp_send_data_length;
  logic [1:0]  tx_src_sel;
  logic        busy;
  logic        tx_timeout_err;
  logic        arp_fail;

  modport master (
    input  cmd_reply_req, cmd_send_len, ad_data_req, ad_send_len,
    input  mac_not_exist, arp_found, mac_send_end,
    output cmd_reply_ack, ad_data_ack, arp_request_req, udp_tx_req,
    output udp_send_data_length, tx_src_sel, busy, tx_timeout_err, arp_fail
  );

  modport slave (
    output cmd_reply_req, cmd_send_len, ad_data_req, ad_send_len,
    output mac_not_exist, arp_found, mac_send_end,
    input  cmd_reply_ack, ad_data_ack, arp_request_req, udp_tx_req,
    input  udp_send_data_length, tx_src_sel, busy, tx_timeout_err, arp_fail
  );
endinterface

// File: rtl/eth_sched_timer.sv
// 32-bit saturating cycle counter with synchronous clear and an expiry compare.
// expired is combinational from the count; the counter never wraps inside a wait.
module eth_sched_timer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic [31:0] limit,
  output logic        expired
);
  logic [31:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 32'd0;
    end else if (clr) begin
      cnt <= 32'd0;
    end else if (en && (cnt != 32'hFFFF_FFFF)) begin
      cnt <= cnt + 32'd1;
    end
  end

  assign expired = (cnt >= limit);
endmodule

// File: rtl/eth_tx_sched.sv
// Arbitrates cmd-reply vs AD-data onto the MAC, resolving the peer MAC by ARP first.
// Ack 1 clk after a request in IDLE, udp_tx_req 1 clk later; holds until mac_send_end/timeout plus IFG.
module eth_tx_sched
  import eth_sched_pkg::*;
#(
  parameter logic [15:0] IFG_CYCLES    = DEF_IFG_CYCLES,
  parameter logic [31:0] TX_TIMEOUT    = DEF_TX_TIMEOUT,
  parameter logic [31:0] ARP_TIMEOUT   = DEF_ARP_TIMEOUT,
  parameter logic [3:0]  ARP_RETRY     = DEF_ARP_RETRY,
  parameter logic [3:0]  MAX_CMD_BURST = DEF_MAX_CMD_BURST,
  parameter logic [15:0] MAX_UDP_LEN   = DEF_MAX_UDP_LEN
) (
  input  logic           clk,
  input  logic           rst_n,
  eth_tx_sched_if.master bus
);
  logic [2:0]  state, state_nxt;
  logic [3:0]  burst_cnt, retry_cnt;
  logic [31:0] tmr_lim;
  logic        tmr_exp, tmr_clr;
  logic        any_req, pick_ad, grant, arp_last;

  assign any_req  = bus.cmd_reply_req | bus.ad_data_req;
  assign pick_ad  = bus.ad_data_req & (~bus.cmd_reply_req | (burst_cnt == MAX_CMD_BURST));
  assign grant    = (state == IDLE) & any_req & ~bus.mac_not_exist;
  assign arp_last = (retry_cnt >= (ARP_RETRY - 4'd1));
  assign bus.busy = (state != IDLE);

  // The timer keeps running through ARP_REQ->ARP_WAIT and SEND->WAIT_END so that
  // the wait windows are measured from the request pulse itself.
  assign tmr_clr = (state_nxt != state) && (state_nxt != ARP_WAIT) && (state_nxt != WAIT_END);

  always_comb begin
    tmr_lim = TX_TIMEOUT - 32'd1;
    case (state)
      ARP_WAIT: tmr_lim = ARP_TIMEOUT - 32'd1;
      GAP:      tmr_lim = (IFG_CYCLES == 16'd0) ? 32'd0 : {16'd0, IFG_CYCLES - 16'd1};
      default:  ;
    endcase
  end

  eth_sched_timer u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (tmr_clr),
    .en      (state != IDLE),
    .limit   (tmr_lim),
    .expired (tmr_exp)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (any_req) state_nxt = bus.mac_not_exist ? ARP_REQ : LOAD;
      ARP_REQ:  state_nxt = ARP_WAIT;
      ARP_WAIT: begin
        if (bus.arp_found)  state_nxt = IDLE;
        else if (tmr_exp)   state_nxt = arp_last ? IDLE : ARP_REQ;
      end
      LOAD:     state_nxt = (bus.udp_send_data_length == 16'd0) ? IDLE : SEND;
      SEND:     state_nxt = WAIT_END;
      WAIT_END: if (bus.mac_send_end || tmr_exp) state_nxt = GAP;
      GAP:      if (tmr_exp) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_cnt <= 4'd0;
    end else if (!bus.ad_data_req) begin
      burst_cnt <= 4'd0;
    end else if (grant) begin
      burst_cnt <= pick_ad ? 4'd0 : burst_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                    <= IDLE;
      retry_cnt                <= 4'd0;
      bus.cmd_reply_ack        <= 1'b0;
      bus.ad_data_ack          <= 1'b0;
      bus.arp_request_req      <= 1'b0;
      bus.udp_tx_req           <= 1'b0;
      bus.udp_send_data_length <= 16'd0;
      bus.tx_src_sel           <= SRC_NONE;
      bus.tx_timeout_err       <= 1'b0;
      bus.arp_fail             <= 1'b0;
    end else begin
      state               <= state_nxt;
      bus.cmd_reply_ack   <= 1'b0;
      bus.ad_data_ack     <= 1'b0;
      bus.arp_request_req <= 1'b0;
      bus.udp_tx_req      <= 1'b0;
      bus.tx_timeout_err  <= 1'b0;
      if (bus.arp_found) bus.arp_fail <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            bus.cmd_reply_ack        <= ~pick_ad;
            bus.ad_data_ack          <= pick_ad;
            bus.tx_src_sel           <= pick_ad ? SRC_AD : SRC_CMD;
            bus.udp_send_data_length <= clamp_len(pick_ad ? bus.ad_send_len : bus.cmd_send_len,
                                                  MAX_UDP_LEN);
          end else if (any_req) begin
            bus.arp_request_req <= 1'b1;
          end
        end
        ARP_WAIT: begin
          if (bus.arp_found) begin
            retry_cnt <= 4'd0;
          end else if (tmr_exp) begin
            if (arp_last) begin
              bus.arp_fail <= 1'b1;
              retry_cnt    <= 4'd0;
            end else begin
              retry_cnt           <= retry_cnt + 4'd1;
              bus.arp_request_req <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (bus.udp_send_data_length == 16'd0) bus.tx_src_sel <= SRC_NONE;
          else                                   bus.udp_tx_req <= 1'b1;
        end
        WAIT_END: if (!bus.mac_send_end && tmr_exp) bus.tx_timeout_err <= 1'b1;
        GAP:      if (tmr_exp) bus.tx_src_sel <= SRC_NONE;
        default:  ;
      endcase
    end
  end
endmodule

// File: tb/tb_eth_tx_sched.sv
// Scenario bench for eth_tx_sched with shortened timeouts and a bench-side arbitration/length model.
module tb_eth_tx_sched;
  localparam int IFG = 12;
  localparam int TXTO = 50;
  localparam int ARPTO = 100;
  localparam int MAXLEN = 1472;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vec = 0;
  int   errs = 0;

  eth_tx_sched_if bus_if();

  eth_tx_sched #(
    .IFG_CYCLES(16'd12), .TX_TIMEOUT(32'd50), .ARP_TIMEOUT(32'd100),
    .ARP_RETRY(4'd3), .MAX_CMD_BURST(4'd4), .MAX_UDP_LEN(16'd1472)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  always #4 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [24:0] all_outs();
    return {bus_if.cmd_reply_ack, bus_if.ad_data_ack, bus_if.arp_request_req, bus_if.udp_tx_req,
            bus_if.udp_send_data_length, bus_if.tx_src_sel, bus_if.busy, bus_if.tx_timeout_err,
            bus_if.arp_fail};
  endfunction

  // One complete transaction; expected ack/length/src come from the length rules alone.
  task automatic do_frame(input bit is_ad, input logic [15:0] len, input int end_dly);
    logic [15:0] exp_len;
    logic [1:0]  exp_src;
    logic [1:0]  exp_ack;
    int n;
    exp_len = (int'(len) > MAXLEN) ? 16'(MAXLEN) : len;
    exp_src = is_ad ? 2'd2 : 2'd1;
    exp_ack = is_ad ? 2'b01 : 2'b10;
    if (is_ad) begin bus_if.ad_data_req = 1'b1; bus_if.ad_send_len = len; end
    else       begin bus_if.cmd_reply_req = 1'b1; bus_if.cmd_send_len = len; end
    tick();
    vec++;
    if ({bus_if.cmd_reply_ack, bus_if.ad_data_ack} !== exp_ack) begin
      errs++; $display("FAIL frame_ack len=%0d: got %b expected %b", len,
                       {bus_if.cmd_reply_ack, bus_if.ad_data_ack}, exp_ack);
    end
    vec++;
    if (bus_if.udp_send_data_length !== exp_len) begin
      errs++; $display("FAIL frame_len: got %0d expected %0d", bus_if.udp_send_data_length, exp_len);
    end
    vec++;
    if (bus_if.tx_src_sel !== exp_src) begin
      errs++; $display("FAIL frame_src: got %0d expected %0d", bus_if.tx_src_sel, exp_src);
    end
    bus_if.cmd_reply_req = 1'b0;
    bus_if.ad_data_req = 1'b0;
    tick();
    if (len == 16'd0) begin
      vec++;
      if ({bus_if.udp_tx_req, bus_if.tx_src_sel, bus_if.busy} !== 4'b0000) begin
        errs++; $display("FAIL zero_len: got tx/src/busy %b expected 0000",
                         {bus_if.udp_tx_req, bus_if.tx_src_sel, bus_if.busy});
      end
    end else begin
      vec++;
      if (bus_if.udp_tx_req !== 1'b1) begin
        errs++; $display("FAIL frame_tx_req: got %b expected 1", bus_if.udp_tx_req);
      end
      repeat (end_dly) tick();
      bus_if.mac_send_end = 1'b1;
      n = 0;
      do begin tick(); n++; bus_if.mac_send_end = 1'b0; end while (bus_if.busy && n < 100);
      vec++;
      if (n != IFG + 1) begin
        errs++; $display("FAIL end_to_idle: got %0d clks expected %0d", n, IFG + 1);
      end
    end
  endtask

  task automatic test_reset();
    bus_if.cmd_reply_req = 1'b0; bus_if.cmd_send_len = 16'd0;
    bus_if.ad_data_req = 1'b0;   bus_if.ad_send_len = 16'd0;
    bus_if.mac_not_exist = 1'b0; bus_if.arp_found = 1'b0; bus_if.mac_send_end = 1'b0;
    #20;
    vec++;
    if (all_outs() !== 25'd0) begin
      errs++; $display("FAIL reset_outs: got %h expected 0", all_outs());
    end
    tick(); rst_n = 1'b1; tick(); tick();
    vec++;
    if (all_outs() !== 25'd0) begin
      errs++; $display("FAIL post_reset_idle: got %h expected 0", all_outs());
    end
  endtask

  task automatic test_cmd_basic();
    do_frame(1'b0, 16'd64, 5);
  endtask

  task automatic test_back_to_back();
    logic [1:0]  got[10];
    logic [1:0]  exp_src;
    logic [15:0] cmd_len, ad_len, exp_len;
    int g, pend, c, burst;
    cmd_len = 16'($urandom_range(1, MAXLEN));
    ad_len  = 16'($urandom_range(1, 3000));
    bus_if.cmd_send_len = cmd_len; bus_if.ad_send_len = ad_len;
    bus_if.cmd_reply_req = 1'b1;   bus_if.ad_data_req = 1'b1;
    g = 0; pend = -1; c = 0; burst = 0;
    while (c < 3000 && (g < 10 || bus_if.busy)) begin
      tick(); c++;
      bus_if.mac_send_end = 1'b0;
      if (pend > 0) pend--;
      if (pend == 0) begin bus_if.mac_send_end = 1'b1; pend = -1; end
      if (bus_if.udp_tx_req) pend = $urandom_range(1, 10);
      if ((bus_if.cmd_reply_ack || bus_if.ad_data_ack) && g < 10) begin
        // Reference arbitration: after 4 straight cmd grants with AD waiting, AD goes next.
        if (burst == 4) begin exp_src = 2'd2; burst = 0; end
        else            begin exp_src = 2'd1; burst++; end
        exp_len = (exp_src == 2'd2) ? ((int'(ad_len) > MAXLEN) ? 16'(MAXLEN) : ad_len) : cmd_len;
        got[g] = {bus_if.ad_data_ack, bus_if.cmd_reply_ack};
        vec++;
        if (got[g] !== exp_src) begin
          errs++; $display("FAIL grant_order[%0d]: got %0d expected %0d", g, got[g], exp_src);
        end
        vec++;
        if (bus_if.udp_send_data_length !== exp_len) begin
          errs++; $display("FAIL grant_len[%0d]: got %0d expected %0d", g,
                           bus_if.udp_send_data_length, exp_len);
        end
        g++;
        if (g == 10) begin bus_if.cmd_reply_req = 1'b0; bus_if.ad_data_req = 1'b0; end
      end
    end
    bus_if.mac_send_end = 1'b0;
    bus_if.cmd_reply_req = 1'b0; bus_if.ad_data_req = 1'b0;
    vec++;
    if (g != 10 || bus_if.busy !== 1'b0) begin
      errs++; $display("FAIL burst_done: got %0d grants busy=%b expected 10 busy=0", g, bus_if.busy);
    end
  endtask

  task automatic test_arp();
    int p[8];
    int np, c, n;
    bit stray;
    np = 0; c = 0; stray = 0;
    bus_if.mac_not_exist = 1'b1;
    bus_if.cmd_send_len = 16'd200;
    bus_if.cmd_reply_req = 1'b1;
    while (c < 1000 && !bus_if.arp_fail) begin
      tick(); c++;
      if (bus_if.arp_request_req && np < 8) begin p[np] = c; np++; end
      if (bus_if.udp_tx_req || bus_if.cmd_reply_ack) stray = 1;
    end
    vec++;
    if (np != 3) begin errs++; $display("FAIL arp_pulses: got %0d expected 3", np); end
    vec++;
    if (np >= 3 && (p[1] - p[0] != ARPTO || p[2] - p[1] != ARPTO)) begin
      errs++; $display("FAIL arp_spacing: got %0d,%0d expected %0d", p[1] - p[0], p[2] - p[1], ARPTO);
    end
    vec++;
    if (np >= 3 && c - p[2] != ARPTO) begin
      errs++; $display("FAIL arp_fail_time: got %0d expected %0d", c - p[2], ARPTO);
    end
    vec++;
    if (stray || bus_if.arp_fail !== 1'b1) begin
      errs++; $display("FAIL arp_fail_state: got stray=%0d fail=%b expected 0,1", stray, bus_if.arp_fail);
    end
    repeat (3) tick();
    bus_if.mac_not_exist = 1'b0;
    bus_if.arp_found = 1'b1;
    tick();
    bus_if.arp_found = 1'b0;
    vec++;
    if (bus_if.arp_fail !== 1'b0) begin
      errs++; $display("FAIL arp_fail_clear: got %b expected 0", bus_if.arp_fail);
    end
    tick();
    vec++;
    if (bus_if.cmd_reply_ack !== 1'b1 || bus_if.udp_send_data_length !== 16'd200) begin
      errs++; $display("FAIL arp_then_ack: got ack=%b len=%0d expected 1,200",
                       bus_if.cmd_reply_ack, bus_if.udp_send_data_length);
    end
    bus_if.cmd_reply_req = 1'b0;
    tick();
    vec++;
    if (bus_if.udp_tx_req !== 1'b1) begin
      errs++; $display("FAIL arp_then_tx: got %b expected 1", bus_if.udp_tx_req);
    end
    repeat (3) tick();
    bus_if.mac_send_end = 1'b1;
    n = 0;
    do begin tick(); n++; bus_if.mac_send_end = 1'b0; end while (bus_if.busy && n < 100);
  endtask

  task automatic test_timeout();
    int k, n;
    bit seen;
    bus_if.cmd_send_len = 16'd100;
    bus_if.cmd_reply_req = 1'b1; tick(); bus_if.cmd_reply_req = 1'b0; tick();
    k = 0;
    do begin tick(); k++; end while (!bus_if.tx_timeout_err && k < 200);
    vec++;
    if (k != TXTO) begin errs++; $display("FAIL timeout_cycle: got %0d expected %0d", k, TXTO); end
    n = 0;
    do begin tick(); n++; end while (bus_if.busy && n < 100);
    vec++;
    if (n != IFG) begin errs++; $display("FAIL timeout_gap: got %0d expected %0d", n, IFG); end
    // mac_send_end lands in the very cycle the timer reaches its limit
    bus_if.cmd_reply_req = 1'b1; tick(); bus_if.cmd_reply_req = 1'b0; tick();
    vec++;
    if (bus_if.udp_tx_req !== 1'b1) begin
      errs++; $display("FAIL timeout2_tx: got %b expected 1", bus_if.udp_tx_req);
    end
    repeat (TXTO - 1) tick();
    bus_if.mac_send_end = 1'b1;
    seen = 0; n = 0;
    do begin
      tick(); n++; bus_if.mac_send_end = 1'b0;
      if (bus_if.tx_timeout_err) seen = 1;
    end while (bus_if.busy && n < 100);
    vec++;
    if (seen) begin errs++; $display("FAIL timeout_tie_err: got 1 expected 0"); end
    vec++;
    if (n != IFG + 1) begin errs++; $display("FAIL timeout_tie_idle: got %0d expected %0d", n, IFG + 1); end
  endtask

  task automatic test_lengths();
    logic [15:0] len;
    bit is_ad;
    do_frame(1'b1, 16'd0, 1);
    do_frame(1'b1, 16'd2000, 3);
    for (int i = 0; i < 8; i++) begin
      is_ad = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
        0: len = 16'd0;
        1: len = 16'd1;
        2: len = 16'd1472;
        3: len = 16'd1473;
        default: len = 16'($urandom_range(1, 4000));
      endcase
      do_frame(is_ad, len, $urandom_range(1, 40));
    end
  endtask

  task automatic test_async_reset();
    bit stray;
    bus_if.cmd_send_len = 16'd300;
    bus_if.cmd_reply_req = 1'b1; tick(); bus_if.cmd_reply_req = 1'b0; tick();
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    vec++;
    if (all_outs() !== 25'd0) begin
      errs++; $display("FAIL async_reset: got %h expected 0", all_outs());
    end
    tick(); tick();
    rst_n = 1'b1;
    stray = 0;
    bus_if.mac_send_end = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      bus_if.mac_send_end = 1'b0;
      if (all_outs() !== 25'd0) stray = 1;
    end
    vec++;
    if (stray) begin errs++; $display("FAIL post_reset_quiet: got activity expected none"); end
    do_frame(1'b0, 16'd80, 2);
  endtask

  initial begin
    test_reset();
    test_cmd_basic();
    test_back_to_back();
    test_arp();
    test_timeout();
    test_lengths();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
